// File: rtl/router_reg_gen.sv
// Packet router front end. Accepts header / payload / parity beats,
// tracks destination, payload length and a running byte check, and
// forwards every accepted byte through a small holding buffer.
module router_reg_gen #(
  parameter int DATA_W      = 8,
  parameter int ADDR_W      = 2,
  parameter int SKID_DEPTH  = 4,
  parameter int PARITY_MODE = 0
) (
  input  logic              clock,
  input  logic              reset,
  input  logic              pkt_valid,
  input  logic [DATA_W-1:0] data_in,
  output logic              in_ready,
  input  logic              fifo_full,
  output logic              out_valid,
  output logic [DATA_W-1:0] dout,
  output logic [ADDR_W-1:0] dest_addr,
  output logic              parity_done,
  output logic              err,
  output logic              len_err
);

  localparam int LEN_W = DATA_W - ADDR_W;
  localparam int PTR_W = $clog2(SKID_DEPTH);
  localparam int CNT_W = PTR_W + 1;

  typedef enum logic [1:0] {IDLE, PAYLOAD, CHECK} state_t;

  // Fold one byte into the running check: XOR, or sum with carry discarded.
  function automatic logic [DATA_W-1:0] fold(input logic [DATA_W-1:0] acc,
                                             input logic [DATA_W-1:0] b);
    if (PARITY_MODE == 1) return acc + b;
    else                  return acc ^ b;
  endfunction

  // Payload counter increment that sticks at its maximum value.
  function automatic logic [LEN_W-1:0] sat_inc(input logic [LEN_W-1:0] v);
    if (v == {LEN_W{1'b1}}) return v;
    else                    return v + LEN_W'(1);
  endfunction

  state_t             state_q, state_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic [PTR_W-1:0]   wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0]   rd_ptr_q, rd_ptr_d;
  logic [DATA_W-1:0]  mem_q [SKID_DEPTH];
  logic [ADDR_W-1:0]  dest_q, dest_d;
  logic               done_q, done_d;
  logic               err_q, err_d;
  logic               lerr_q, lerr_d;
  logic [LEN_W-1:0]   len_q, len_d;
  logic [LEN_W-1:0]   plcnt_q, plcnt_d;
  logic [DATA_W-1:0]  chk_q, chk_d;
  logic [DATA_W-1:0]  par_q, par_d;
  logic               accept;
  logic               push;
  logic               pop;

  // Handshake, buffer bookkeeping and next-state / flag computation.
  always_comb begin
    in_ready = (state_q != CHECK) && (cnt_q < CNT_W'(SKID_DEPTH));
    accept   = in_ready && ((state_q == PAYLOAD) ||
                            ((state_q == IDLE) && pkt_valid));
    push     = accept;
    pop      = (cnt_q != '0) && !fifo_full;

    wr_ptr_d = push ? wr_ptr_q + PTR_W'(1) : wr_ptr_q;
    rd_ptr_d = pop  ? rd_ptr_q + PTR_W'(1) : rd_ptr_q;
    case ({push, pop})
      2'b10:   cnt_d = cnt_q + CNT_W'(1);
      2'b01:   cnt_d = cnt_q - CNT_W'(1);
      default: cnt_d = cnt_q;
    endcase

    state_d = state_q;
    dest_d  = dest_q;
    done_d  = done_q;
    err_d   = err_q;
    lerr_d  = lerr_q;
    len_d   = len_q;
    plcnt_d = plcnt_q;
    chk_d   = chk_q;
    par_d   = par_q;

    case (state_q)
      IDLE: begin
        if (accept) begin
          state_d = PAYLOAD;
          dest_d  = data_in[ADDR_W-1:0];
          len_d   = data_in[DATA_W-1:ADDR_W];
          plcnt_d = '0;
          chk_d   = data_in;
          done_d  = 1'b0;
          err_d   = 1'b0;
          lerr_d  = 1'b0;
        end
      end
      PAYLOAD: begin
        if (accept) begin
          if (pkt_valid) begin
            chk_d   = fold(chk_q, data_in);
            plcnt_d = sat_inc(plcnt_q);
          end else begin
            par_d   = data_in;
            state_d = CHECK;
          end
        end
      end
      CHECK: begin
        done_d  = 1'b1;
        err_d   = (chk_q != par_q);
        lerr_d  = (plcnt_q != len_q);
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase

    out_valid   = (cnt_q != '0);
    dout        = out_valid ? mem_q[rd_ptr_q] : '0;
    dest_addr   = dest_q;
    parity_done = done_q;
    err         = err_q;
    len_err     = lerr_q;
  end

  // Control state: FSM, buffer pointers/count, destination and status flags.
  always_ff @(posedge clock) begin
    if (reset) begin
      state_q  <= IDLE;
      cnt_q    <= '0;
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      dest_q   <= '0;
      done_q   <= 1'b0;
      err_q    <= 1'b0;
      lerr_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      dest_q   <= dest_d;
      done_q   <= done_d;
      err_q    <= err_d;
      lerr_q   <= lerr_d;
    end
  end

  // Datapath registers: buffer storage and per-packet length/check/parity.
  always_ff @(posedge clock) begin
    if (push) mem_q[wr_ptr_q] <= data_in;
    len_q   <= len_d;
    plcnt_q <= plcnt_d;
    chk_q   <= chk_d;
    par_q   <= par_d;
  end

endmodule

// File: tb/tb_router_reg_gen.sv
// Directed bench for router_reg_gen: XOR-mode and sum-mode instances share
// the same stimulus; forwarded bytes of the XOR instance are collected.
module tb_router_reg_gen;

  logic       clock;
  logic       reset;
  logic       pkt_valid;
  logic [7:0] data_in;
  logic       fifo_full;

  logic       in_ready0, out_valid0, done0, err0, lerr0;
  logic [7:0] dout0;
  logic [1:0] dest0;
  logic       in_ready1, out_valid1, done1, err1, lerr1;
  logic [7:0] dout1;
  logic [1:0] dest1;

  int vectors;
  int miscompares;
  logic [7:0] got[$];

  router_reg_gen #(.DATA_W(8), .ADDR_W(2), .SKID_DEPTH(4), .PARITY_MODE(0)) dut0 (
    .clock(clock), .reset(reset), .pkt_valid(pkt_valid), .data_in(data_in),
    .in_ready(in_ready0), .fifo_full(fifo_full), .out_valid(out_valid0),
    .dout(dout0), .dest_addr(dest0), .parity_done(done0), .err(err0),
    .len_err(lerr0));

  router_reg_gen #(.DATA_W(8), .ADDR_W(2), .SKID_DEPTH(4), .PARITY_MODE(1)) dut1 (
    .clock(clock), .reset(reset), .pkt_valid(pkt_valid), .data_in(data_in),
    .in_ready(in_ready1), .fifo_full(fifo_full), .out_valid(out_valid1),
    .dout(dout1), .dest_addr(dest1), .parity_done(done1), .err(err1),
    .len_err(lerr1));

  initial clock = 1'b0;
  always #5 clock = ~clock;

  // Record every byte that the downstream side will consume at the next edge.
  always @(negedge clock) begin
    if (!reset && out_valid0 && !fifo_full) got.push_back(dout0);
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Present one beat and hold it until the XOR instance takes it.
  task automatic send(input logic v, input logic [7:0] d);
    bit ok;
    pkt_valid = v;
    data_in   = d;
    ok        = 1'b0;
    for (int n = 0; n < 50 && !ok; n++) begin
      @(negedge clock);
      ok = in_ready0;
      @(posedge clock);
      #1;
    end
    if (!ok) begin
      vectors++;
      miscompares++;
      $error("FAIL send_timeout observed=in_ready_low expected=accept data=%0h", d);
    end
  endtask

  task automatic pkt(input logic [7:0] h, input logic [7:0] p[4], input int n,
                     input logic [7:0] par);
    send(1'b1, h);
    for (int i = 0; i < n; i++) send(1'b1, p[i]);
    send(1'b0, par);
    pkt_valid = 1'b0;
    @(posedge clock);
    #1;
  endtask

  task automatic cycles(input int n);
    repeat (n) @(posedge clock);
    #1;
  endtask

  task automatic chk_out(input string tag, input logic [7:0] e[6], input int n);
    chk({tag, "_count"}, got.size(), n);
    for (int i = 0; i < n; i++)
      chk($sformatf("%s_byte%0d", tag, i), (i < got.size()) ? got[i] : 8'hxx, e[i]);
  endtask

  initial begin
    logic [7:0] pl[4];
    logic [7:0] seq[6];
    logic [7:0] stream[6];
    vectors     = 0;
    miscompares = 0;
    pl     = '{8'h01, 8'h02, 8'h03, 8'h04};
    seq    = '{8'h11, 8'h01, 8'h02, 8'h03, 8'h04, 8'h15};
    stream = '{8'h11, 8'h01, 8'h02, 8'h03, 8'h04, 8'h15};

    reset = 1'b1; pkt_valid = 1'b0; data_in = 8'h00; fifo_full = 1'b0;
    cycles(3);
    chk("rst_out_valid", out_valid0, 1'b0);
    chk("rst_dout", dout0, 8'h00);
    chk("rst_in_ready", in_ready0, 1'b1);
    chk("rst_dest", dest0, 2'd0);
    chk("rst_flags", {done0, err0, lerr0}, 3'b000);
    reset = 1'b0;
    cycles(1);

    // Idle beats with pkt_valid low are ignored.
    data_in = 8'h5A;
    cycles(2);
    chk("idle_ignore", out_valid0, 1'b0);

    // Good packet, each byte visible on dout right after acceptance.
    got.delete();
    for (int i = 0; i < 6; i++) begin
      send(i < 5, seq[i]);
      chk($sformatf("lat_valid%0d", i), out_valid0, 1'b1);
      chk($sformatf("lat_dout%0d", i), dout0, seq[i]);
    end
    pkt_valid = 1'b0;
    cycles(1);
    chk("good_flags", {done0, err0, lerr0}, 3'b100);
    chk("good_dest", dest0, 2'd1);
    chk("good_mode1_err", {done1, err1, lerr1}, 3'b110);
    cycles(3);
    chk_out("good_out", stream, 6);
    chk("good_drained", out_valid0, 1'b0);

    // Corrupt parity byte, then flags cleared by the next header.
    pkt(8'h11, pl, 4, 8'hEA);
    chk("bad_par_flags", {done0, err0, lerr0}, 3'b110);
    send(1'b1, 8'h11);
    chk("hdr_clears", {done0, err0, lerr0}, 3'b000);
    for (int i = 0; i < 4; i++) send(1'b1, pl[i]);
    send(1'b0, 8'h15);
    pkt_valid = 1'b0;
    cycles(1);
    chk("after_clear_flags", {done0, err0, lerr0}, 3'b100);

    // Short packet: three payload bytes against LEN=4.
    pkt(8'h11, pl, 3, 8'h11);
    chk("len_flags", {done0, err0, lerr0}, 3'b101);

    // LEN=0, destination 2: header 02, parity 02.
    pkt(8'h02, pl, 0, 8'h02);
    chk("len0_flags", {done0, err0, lerr0}, 3'b100);
    chk("len0_dest", dest0, 2'd2);
    cycles(3);

    // Backpressure from the header onward.
    got.delete();
    fifo_full = 1'b1;
    send(1'b1, 8'h11);
    for (int i = 0; i < 3; i++) send(1'b1, pl[i]);
    chk("bp_ready_low", in_ready0, 1'b0);
    chk("bp_head", dout0, 8'h11);
    pkt_valid = 1'b1; data_in = 8'h04;
    cycles(3);
    chk("bp_still_low", in_ready0, 1'b0);
    chk("bp_no_pop", got.size(), 0);
    fifo_full = 1'b0;
    send(1'b1, 8'h04);
    send(1'b0, 8'h15);
    pkt_valid = 1'b0;
    cycles(8);
    chk_out("bp_out", stream, 6);
    chk("bp_flags", {done0, err0, lerr0}, 3'b100);

    // Sum mode: 1B is the correct check byte there.
    pkt(8'h11, pl, 4, 8'h1B);
    chk("m1_good", {done1, err1, lerr1}, 3'b100);
    chk("m0_on_1b", err0, 1'b1);
    cycles(3);

    // Reset after the second payload byte, then a clean packet.
    send(1'b1, 8'h11);
    send(1'b1, 8'h01);
    send(1'b1, 8'h02);
    reset = 1'b1; pkt_valid = 1'b0;
    @(posedge clock);
    #1;
    reset = 1'b0;
    chk("mid_rst_valid", out_valid0, 1'b0);
    chk("mid_rst_ready", in_ready0, 1'b1);
    chk("mid_rst_flags", {done0, err0, lerr0}, 3'b000);
    chk("mid_rst_dest", dest0, 2'd0);
    got.delete();
    pkt(8'h11, pl, 4, 8'h15);
    chk("post_rst_flags", {done0, err0, lerr0}, 3'b100);
    chk("post_rst_dest", dest0, 2'd1);
    cycles(3);
    chk_out("post_rst_out", stream, 6);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/router_reg_gen.md
ROUTER_REG_GEN -- requirements
Module: router_reg_gen

Interface
REQ-001 SHALL have parameter DATA_W, default 8, byte width of data_in/dout.
REQ-002 SHALL have parameter ADDR_W, default 2, header address field width; header[DATA_W-1:ADDR_W] is the payload length LEN.
REQ-003 SHALL have parameter SKID_DEPTH, default 4, internal holding-buffer entries, power of two, >=2.
REQ-004 SHALL have parameter PARITY_MODE, default 0: 0 = XOR of all bytes, 1 = sum modulo 2^DATA_W.
REQ-005 SHALL have port clock  input  1  single clock, all logic on rising edge.
REQ-006 SHALL have port reset  input  1  synchronous, active-high reset.
REQ-007 SHALL have port pkt_valid  input  1  high for header and payload beats, low for the parity beat.
REQ-008 SHALL have port data_in  input  DATA_W  header, payload or parity byte.
REQ-009 SHALL have port in_ready  output  1  a beat is accepted in a cycle where in_ready=1 and the state machine treats the beat as valid (REQ-016..018).
REQ-010 SHALL have port fifo_full  input  1  downstream backpressure; dout is consumed when out_valid=1 and fifo_full=0.
REQ-011 SHALL have port out_valid  output  1  dout holds a valid byte.
REQ-012 SHALL have port dout  output  DATA_W  forwarded byte, oldest first.
REQ-013 SHALL have port dest_addr  output  ADDR_W  address of the current/last header.
REQ-014 SHALL have ports parity_done, err, len_err  output  1 each  end-of-packet status flags.

Function
REQ-015 SHALL implement states IDLE, PAYLOAD, CHECK.
REQ-016 IDLE: pkt_valid=1 and in_ready=1 accepts header -> PAYLOAD; capture dest_addr, LEN, zero payload counter, seed running check with header, clear parity_done/err/len_err; pkt_valid=0 ignored.
REQ-017 PAYLOAD: accepted beat with pkt_valid=1 is payload -> fold into running check, increment payload counter (saturating at 2^(DATA_W-ADDR_W)-1).
REQ-018 PAYLOAD: accepted beat with pkt_valid=0 is parity byte -> register it, go to CHECK.
REQ-019 CHECK (exactly one cycle): set parity_done=1; err=1 iff running check != parity byte; len_err=1 iff payload counter != LEN; -> IDLE.
REQ-020 parity_done/err/len_err SHALL hold until next header is accepted or reset.
REQ-021 LEN=0 SHALL be legal: header directly followed by parity beat.
REQ-022 Every accepted byte (header, payload, parity) SHALL be pushed to the holding buffer in acceptance order; none dropped, none duplicated.
REQ-023 in_ready SHALL equal (state != CHECK) and (buffer count < SKID_DEPTH); no push when full even if a pop occurs the same cycle.
REQ-024 out_valid SHALL equal (count != 0); dout = oldest entry; pop when out_valid=1 and fifo_full=0.
REQ-025 Latency: byte accepted at edge N SHALL be on dout with out_valid=1 after edge N when buffer was empty.
REQ-026 Simultaneous push and pop SHALL leave count unchanged; pointers wrap modulo SKID_DEPTH.
REQ-027 Running check width DATA_W; mode 1 discards carry.

Reset
REQ-028 reset=1 at a rising edge SHALL force state IDLE, buffer empty, out_valid=0, dout=0, dest_addr=0, parity_done=err=len_err=0, in_ready=1 after the edge, including mid-packet; partially received packet discarded.

Verification (DATA_W=8, ADDR_W=2, SKID_DEPTH=4)
REQ-029 Good packet, mode 0, fifo_full=0: header 8'h11, payload 01,02,03,04, parity 15 -> dout 11,01,02,03,04,15 each one cycle after acceptance; parity_done=1, err=0, len_err=0, dest_addr=1.
REQ-030 Corrupt parity: same packet, parity EA -> err=1, len_err=0, parity_done=1; cleared on next header.
REQ-031 Length mismatch: header 11, payload 01,02,03, parity 11 -> len_err=1, err=0.
REQ-032 Backpressure: fifo_full=1 from header onward -> 4 bytes accepted, in_ready=0 after 4th; release fifo_full -> all 6 bytes out in order, none lost.
REQ-033 Mode 1: header 11, payload 01,02,03,04, parity 1B -> err=0; parity 15 -> err=1.
REQ-034 Reset asserted after 2nd payload byte -> next cycle out_valid=0, in_ready=1, flags 0; following good packet per REQ-029 passes.
